note_scheduler: RTL and testbench

//  Sequences the tone datapath (note divider -> buzzer_Ctrl -> speaker_Ctrl). Arbitrates

---
 rtl/note_pkg.sv | 40 ++++
 rtl/melody_seq.sv | 108 ++++++++++
 rtl/note_scheduler.sv | 93 +++++++++
 tb/tb_note_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler.
//   NOTE_REST / NOTE_END : reserved note codes (silence, melody end-of-song marker)
//   NOTE_DIV_W           : natural width of the divider table entries
//   seq_state_e          : melody sequencer state encoding
//   note_to_div()        : note code -> clock divider (100 MHz / f), 0 = silence
package note_pkg;

    localparam logic [3:0] NOTE_REST  = 4'h0;
    localparam logic [3:0] NOTE_END   = 4'hF;
    localparam int         NOTE_DIV_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    // Codes 1-7 are C4-B4, 8-14 are C5-B5; rest and end-marker stay silent.
    function automatic logic [NOTE_DIV_W-1:0] note_to_div(input logic [3:0] code);
        case (code)
            4'd1:    note_to_div = 22'd382219;
            4'd2:    note_to_div = 22'd340524;
            4'd3:    note_to_div = 22'd303372;
            4'd4:    note_to_div = 22'd286344;
            4'd5:    note_to_div = 22'd255102;
            4'd6:    note_to_div = 22'd227272;
            4'd7:    note_to_div = 22'd202478;
            4'd8:    note_to_div = 22'd191110;
            4'd9:    note_to_div = 22'd170262;
            4'd10:   note_to_div = 22'd151686;
            4'd11:   note_to_div = 22'd143172;
            4'd12:   note_to_div = 22'd127551;
            4'd13:   note_to_div = 22'd113636;
            4'd14:   note_to_div = 22'd101239;
            default: note_to_div = '0;
        endcase
    endfunction

endpackage

// File: rtl/melody_seq.sv
// Melody playback sequencer: walks the melody ROM one step per beat.
// Each step is one LOAD cycle (ROM sample) followed by BEAT_CYCLES cycles,
// of which the last GAP_CYCLES are silent for articulation.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pause_i        freeze FSM and beat counter (keyboard has the speaker)
//   play_req_i     start from step 0 when idle
//   stop_req_i     abort to idle, overrides everything except reset
//   rom_code_i     melody ROM data for rom_addr_o
//   rom_addr_o     current melody step
//   state_o        current sequencer state
//   code_o         note code latched at the last LOAD
//   busy_o         sequencer is in LOAD/PLAY/GAP
module melody_seq
    import note_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int SONG_LEN    = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause_i,
    input  logic              play_req_i,
    input  logic              stop_req_i,
    input  logic [3:0]        rom_code_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output seq_state_e        state_o,
    output logic [3:0]        code_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  PLAY_LAST = CNT_W'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        code_q;
    logic              busy_q;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || stop_req_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            code_q  <= NOTE_REST;
            busy_q  <= 1'b0;
        end else if (!pause_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (play_req_i) begin
                        state_q <= ST_LOAD;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (rom_code_i == NOTE_END) begin
                        state_q <= ST_IDLE;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        code_q  <= rom_code_i;
                        cnt_q   <= '0;
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cnt_q == PLAY_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        // Last ROM slot ends the song; there is no wrap-around replay.
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_IDLE;
                            addr_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr_o = addr_q;
    assign state_o    = state_q;
    assign code_o     = code_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: arbitrates live keyboard notes against melody playback and
// drives the tone datapath with a registered divider and note code.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   key_valid    a note key is held (takes priority, pauses the melody)
//   key_code     note code of the held key
//   play_req     start melody from step 0 (ignored while busy)
//   stop_req     abort melody (wins over a same-cycle play_req)
//   rom_addr     melody ROM address
//   rom_code     melody ROM data (combinational read), 4'hF = end-of-song
//   note_div     divider to buzzer_Ctrl, 0 = silence
//   note_code    code currently sounding, 0 when silent
//   busy         melody sequencer active
//   src_key      output is driven by the keyboard
module note_scheduler
    import note_pkg::*;
#(
    parameter  int BEAT_CYCLES = 25_000_000,
    parameter  int GAP_CYCLES  = 2_500_000,
    parameter  int SONG_LEN    = 16,
    parameter  int DIV_W       = 22,
    localparam int ADDR_W      = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              play_req,
    input  logic              stop_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_code,
    output logic [DIV_W-1:0]  note_div,
    output logic [3:0]        note_code,
    output logic              busy,
    output logic              src_key
);

    seq_state_e seq_state;
    logic [3:0] seq_code;

    melody_seq #(
        .BEAT_CYCLES (BEAT_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .SONG_LEN    (SONG_LEN),
        .ADDR_W      (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .pause_i    (key_valid),
        .play_req_i (play_req),
        .stop_req_i (stop_req),
        .rom_code_i (rom_code),
        .rom_addr_o (rom_addr),
        .state_o    (seq_state),
        .code_o     (seq_code),
        .busy_o     (busy)
    );

    logic [3:0]       sel_code;
    logic [DIV_W-1:0] note_div_d, note_div_q;
    logic [3:0]       note_code_d, note_code_q;
    logic             src_key_q;

    // Key wins; otherwise only PLAY sounds. A stop silences the melody in the
    // same cycle the sequencer drops to IDLE.
    always_comb begin
        sel_code = NOTE_REST;
        if (key_valid) begin
            sel_code = key_code;
        end else if (seq_state == ST_PLAY && !stop_req) begin
            sel_code = seq_code;
        end
        note_div_d  = DIV_W'(note_to_div(sel_code));
        note_code_d = (note_to_div(sel_code) == '0) ? NOTE_REST : sel_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_div_q  <= '0;
            note_code_q <= NOTE_REST;
            src_key_q   <= 1'b0;
        end else begin
            note_div_q  <= note_div_d;
            note_code_q <= note_code_d;
            src_key_q   <= key_valid;
        end
    end

    assign note_div  = note_div_q;
    assign note_code = note_code_q;
    assign src_key   = src_key_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: directed scenarios followed by
// randomized keyboard/play/stop/reset traffic, all compared against a
// step/offset timeline model of the melody.
module tb_note_scheduler;

    localparam int BEAT  = 8;
    localparam int GAP   = 2;
    localparam int SONG  = 4;
    localparam int DIV_W = 22;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst, key_valid, play_req, stop_req;
    logic [3:0]       key_code, rom_code;
    logic [AW-1:0]    rom_addr;
    logic [DIV_W-1:0] note_div;
    logic [3:0]       note_code;
    logic             busy, src_key;
    logic [3:0]       rom_mem [SONG];

    always #5 clk = ~clk;

    assign rom_code = rom_mem[rom_addr];

    note_scheduler #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_LEN    (SONG),
        .DIV_W       (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .rom_addr  (rom_addr),
        .rom_code  (rom_code),
        .note_div  (note_div),
        .note_code (note_code),
        .busy      (busy),
        .src_key   (src_key)
    );

    int div_tab [16] = '{0, 382219, 340524, 303372, 286344, 255102, 227272, 202478,
                         191110, 170262, 151686, 143172, 127551, 113636, 101239, 0};

    int n_vec = 0;
    int n_err = 0;
    int seen [16];

    // Melody model: a song is a sequence of steps, each BEAT+1 cycles long.
    // Offset 0 is the ROM sample, offsets 1..BEAT-GAP sound, the rest are silent.
    bit m_active = 1'b0;
    int m_step   = 0;
    int m_off    = 0;
    int m_code   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 16; i++) seen[i] = 0;
    endtask

    task automatic cyc(input bit r, input bit kv, input int kc, input bit pl, input bit st);
        int e_code;
        bit e_key;
        rst       = r;
        key_valid = kv;
        key_code  = kc[3:0];
        play_req  = pl;
        stop_req  = st;
        if (r) begin
            e_code = 0;
            e_key  = 1'b0;
        end else if (kv) begin
            e_code = kc;
            e_key  = 1'b1;
        end else begin
            e_key  = 1'b0;
            e_code = (m_active && m_off >= 1 && m_off <= BEAT - GAP && !st) ? m_code : 0;
        end
        if (div_tab[e_code] == 0) e_code = 0;

        if (r || st) begin
            m_active = 1'b0;
            m_step   = 0;
            m_off    = 0;
        end else if (!kv) begin
            if (!m_active) begin
                if (pl) begin
                    m_active = 1'b1;
                    m_step   = 0;
                    m_off    = 0;
                end
            end else if (m_off == 0) begin
                if (rom_mem[m_step] == 4'hF) begin
                    m_active = 1'b0;
                    m_step   = 0;
                end else begin
                    m_code = int'(rom_mem[m_step]);
                    m_off  = 1;
                end
            end else if (m_off == BEAT) begin
                if (m_step == SONG - 1) begin
                    m_active = 1'b0;
                    m_step   = 0;
                end else begin
                    m_step++;
                end
                m_off = 0;
            end else begin
                m_off++;
            end
        end

        @(posedge clk);
        #1;
        check("note_code", int'(note_code), e_code);
        check("note_div",  int'(note_div),  div_tab[e_code]);
        check("src_key",   int'(src_key),   int'(e_key));
        check("busy",      int'(busy),      int'(m_active));
        check("rom_addr",  int'(rom_addr),  m_step);
        seen[note_code]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit kv;
        int kc;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; play_req = 1'b0; stop_req = 1'b0;
        for (int i = 0; i < SONG; i++) rom_mem[i] = 4'd0;
        clear_seen();

        // Reset held with play_req asserted: everything stays quiet and idle.
        repeat (3) cyc(1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("rst_div", int'(note_div), 0);
        check("rst_busy", int'(busy), 0);
        idle(3);
        check("post_rst_busy", int'(busy), 0);

        // Song with end marker in slot 3.
        rom_mem = '{4'd6, 4'd1, 4'd8, 4'hF};
        clear_seen();
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(35);
        check("t2_code6_cycles", seen[6], 6);
        check("t2_code1_cycles", seen[1], 6);
        check("t2_code8_cycles", seen[8], 6);
        check("t2_end_busy", int'(busy), 0);
        check("t2_end_addr", int'(rom_addr), 0);

        // Full-length song: four steps and no replay.
        rom_mem = '{4'd1, 4'd2, 4'd3, 4'd4};
        clear_seen();
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(45);
        for (int c = 1; c <= 4; c++) check("t3_step_cycles", seen[c], 6);
        check("t3_end_busy", int'(busy), 0);

        // Key press pauses step 0 after three PLAY cycles, then resumes.
        rom_mem = '{4'd6, 4'd1, 4'd8, 4'hF};
        clear_seen();
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(4);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 5, 1'b0, 1'b0);
        check("t4_key_cycles", seen[5], 10);
        idle(35);
        check("t4_code6_cycles", seen[6], 6);
        check("t4_code1_cycles", seen[1], 6);

        // Stop and play together while busy: stop wins.
        rom_mem = '{4'd1, 4'd2, 4'd3, 4'd4};
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("t5_busy", int'(busy), 0);
        check("t5_addr", int'(rom_addr), 0);
        check("t5_div", int'(note_div), 0);
        idle(3);

        // Rest and end-marker codes from the keyboard are silent but keyboard-sourced.
        cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("t6_rest_src", int'(src_key), 1);
        cyc(1'b0, 1'b1, 15, 1'b0, 1'b0);
        check("t6_end_div", int'(note_div), 0);
        check("t6_end_code", int'(note_code), 0);
        idle(2);

        // Randomized traffic.
        kv = 1'b0;
        kc = 0;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < SONG; i++) rom_mem[i] = 4'($urandom_range(0, 15));
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 11) == 0) begin
                    kv = ~kv;
                    kc = int'($urandom_range(0, 15));
                end
                cyc($urandom_range(0, 399) == 0, kv, kc,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
